// File: rtl/register_file_logic_pkg.sv
// Shared widths, entry types and reset-init patterns for the dual register-file block.
package register_file_logic_pkg;

  localparam int A_AW    = 3;
  localparam int A_DW    = 4;
  localparam int A_DEPTH = 8;
  localparam int B_AW    = 4;
  localparam int B_DW    = 8;
  localparam int B_DEPTH = 16;

  typedef logic [A_DW-1:0] aEntry_t;
  typedef logic [B_DW-1:0] bEntry_t;

  // Reset-init selectors: entry i holds i, or the low nibble of i repeated.
  localparam int INIT_INDEX     = 0;
  localparam int INIT_NIBBLE_X2 = 1;

  function automatic logic [31:0] initValue(input int sel, input int idx);
    logic [3:0] nib;
    nib = idx[3:0];
    if (sel == INIT_NIBBLE_X2) return {24'd0, nib, nib};
    else                       return idx;
  endfunction

endpackage

// File: rtl/register_file_logic_regfile.sv
// Generic register file: synchronous write, combinational multi-port read, patterned reset.
module regfile
  import register_file_logic_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int NREAD    = 1,
  parameter int INIT_SEL = INIT_INDEX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wrEn,
  input  logic [ADDR_W-1:0]       wrAddr,
  input  logic [DATA_W-1:0]       wrData,
  input  logic [NREAD*ADDR_W-1:0] rdAddr,
  output logic [NREAD*DATA_W-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[ADDR_W'(i)] <= DATA_W'(initValue(INIT_SEL, i));
    end else if (en && wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // No write bypass: reads always see the pre-edge array contents.
  for (genvar r = 0; r < NREAD; r++) begin : gRead
    assign rdData[r*DATA_W +: DATA_W] = mem[rdAddr[r*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/register_file_logic.sv
// Dual register file (A: 8x4, two reads; B: 16x8, one read) feeding a registered combine stage.
module register_file_logic
  import register_file_logic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [A_AW-1:0] ReadRegA1,
  input  logic [A_AW-1:0] ReadRegA2,
  input  logic [A_AW-1:0] WriteRegA,
  input  logic            WriteEnA,
  input  logic [A_DW-1:0] WriteDataA,
  input  logic [B_AW-1:0] ReadRegB,
  input  logic [B_AW-1:0] WriteRegB,
  input  logic            WriteEnB,
  input  logic [B_DW-1:0] WriteDataB,
  output logic [A_DW-1:0] out1,
  output logic [A_DW-1:0] out2
);

  aEntry_t             rA1_p0, rA2_p0;
  bEntry_t             rB_p0;
  logic [2*A_AW-1:0]   aRdAddr;
  logic [2*A_DW-1:0]   aRdData;
  aEntry_t             out1_p1, out2_p1;

  function automatic aEntry_t addWrap(input aEntry_t a, input aEntry_t b);
    return a + b;
  endfunction

  assign aRdAddr          = {ReadRegA2, ReadRegA1};
  assign {rA2_p0, rA1_p0} = aRdData;

  regfile #(
    .ADDR_W   (A_AW),
    .DATA_W   (A_DW),
    .NREAD    (2),
    .INIT_SEL (INIT_INDEX)
  ) fileA (
    .clk    (clk),
    .rst    (rst),
    .en     (start),
    .wrEn   (WriteEnA),
    .wrAddr (WriteRegA),
    .wrData (WriteDataA),
    .rdAddr (aRdAddr),
    .rdData (aRdData)
  );

  regfile #(
    .ADDR_W   (B_AW),
    .DATA_W   (B_DW),
    .NREAD    (1),
    .INIT_SEL (INIT_NIBBLE_X2)
  ) fileB (
    .clk    (clk),
    .rst    (rst),
    .en     (start),
    .wrEn   (WriteEnB),
    .wrAddr (WriteRegB),
    .wrData (WriteDataB),
    .rdAddr (ReadRegB),
    .rdData (rB_p0)
  );

  // Stage p0 -> p1: combine the reads and register the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_p1 <= '0;
      out2_p1 <= '0;
    end else if (start) begin
      out1_p1 <= addWrap(rA1_p0, rB_p0[3:0]);
      out2_p1 <= rA2_p0 ^ rB_p0[7:4];
    end
  end

  assign out1 = out1_p1;
  assign out2 = out2_p1;

endmodule

// File: tb/tb_register_file_logic.sv
// Directed bench for register_file_logic: hand-computed outputs checked after each edge.
module tb_register_file_logic;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] ReadRegA1, ReadRegA2, WriteRegA;
  logic       WriteEnA;
  logic [3:0] WriteDataA;
  logic [3:0] ReadRegB, WriteRegB;
  logic       WriteEnB;
  logic [7:0] WriteDataB;
  logic [3:0] out1, out2;

  int compared = 0;
  int mismatched = 0;

  register_file_logic dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ReadRegA1  (ReadRegA1),
    .ReadRegA2  (ReadRegA2),
    .WriteRegA  (WriteRegA),
    .WriteEnA   (WriteEnA),
    .WriteDataA (WriteDataA),
    .ReadRegB   (ReadRegB),
    .WriteRegB  (WriteRegB),
    .WriteEnB   (WriteEnB),
    .WriteDataB (WriteDataB),
    .out1       (out1),
    .out2       (out2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setWrite(input logic enA, input logic [2:0] addrA, input logic [3:0] dataA,
                          input logic enB, input logic [3:0] addrB, input logic [7:0] dataB);
    WriteEnA = enA; WriteRegA = addrA; WriteDataA = dataA;
    WriteEnB = enB; WriteRegB = addrB; WriteDataB = dataB;
  endtask

  task automatic setRead(input logic [2:0] a1, input logic [2:0] a2, input logic [3:0] b);
    ReadRegA1 = a1; ReadRegA2 = a2; ReadRegB = b;
  endtask

  initial begin
    // Reset edge with start and a write both active: the write must be dropped.
    rst = 1'b1; start = 1'b1;
    setWrite(1'b1, 3'd3, 4'hF, 1'b1, 4'd3, 8'h00);
    setRead(3'd3, 3'd2, 4'd3);
    step();
    check("reset_out1", out1, 4'h0);
    check("reset_out2", out2, 4'h0);

    rst = 1'b0;
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    step();
    check("init_out1", out1, 4'h6);   // A[3]=3 + B[3][3:0]=3
    check("init_out2", out2, 4'h1);   // A[2]=2 ^ B[3][7:4]=3

    setWrite(1'b1, 3'd4, 4'h8, 1'b1, 4'd8, 8'hCF);
    step();
    check("dual_write_out1", out1, 4'h6);
    setWrite(1'b1, 3'd6, 4'h0, 1'b0, 4'd0, 8'h00);
    step();
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    setRead(3'd4, 3'd6, 4'd8);
    step();
    check("combine_out1", out1, 4'h7);  // (8 + F) mod 16
    check("combine_out2", out2, 4'hC);  // 0 ^ C

    // Same-edge write and read of A[5]: old value 5 first, then 9.
    setWrite(1'b1, 3'd5, 4'h9, 1'b0, 4'd0, 8'h00);
    setRead(3'd5, 3'd6, 4'd8);
    step();
    check("same_edge_old", out1, 4'h4); // 5 + F = 0x14
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    step();
    check("same_edge_new", out1, 4'h8); // 9 + F = 0x18

    // start low: write suppressed, outputs hold.
    start = 1'b0;
    setWrite(1'b1, 3'd1, 4'hF, 1'b0, 4'd0, 8'h00);
    setRead(3'd1, 3'd6, 4'd8);
    step();
    check("hold_out1", out1, 4'h8);
    check("hold_out2", out2, 4'hC);
    start = 1'b1;
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    step();
    check("no_write_when_idle", out1, 4'h0); // A[1]=1 + F = 0x10

    // Mid-operation reset restores init patterns.
    rst = 1'b1;
    setRead(3'd4, 3'd6, 4'd8);
    step();
    check("rst2_out1", out1, 4'h0);
    check("rst2_out2", out2, 4'h0);
    rst = 1'b0;
    step();
    check("rst2_A4_B8", out1, 4'hC);    // A[4]=4 + B[8][3:0]=8
    check("rst2_A6_B8", out2, 4'hE);    // A[6]=6 ^ 8

    // Wrap check, both writes on address 0 of B.
    setWrite(1'b1, 3'd7, 4'hF, 1'b1, 4'd0, 8'h0F);
    step();
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    setRead(3'd7, 3'd2, 4'd0);
    step();
    check("wrap_out1", out1, 4'hE);     // F + F = 0x1E
    check("wrap_out2", out2, 4'h2);     // A[2]=2 ^ 0

    // Address 0 of A is an ordinary register.
    setWrite(1'b1, 3'd0, 4'hA, 1'b0, 4'd0, 8'h00);
    step();
    setWrite(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 8'h00);
    setRead(3'd0, 3'd0, 4'd0);
    step();
    check("a0_out1", out1, 4'h9);       // A + F = 0x19
    check("a0_out2", out2, 4'hA);       // A ^ 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
